// File: rtl/spi_transaction_fsm.sv
// SPI memory transaction sequencer: address/RW byte, then one data byte read or written.
// Optional abort_flag output when SPI_TRANSACTION_ABORT_FLAG_EN is defined.
module spi_transaction_fsm #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  sclk_rise,
  input  logic                  sclk_fall,
  input  logic [DATA_WIDTH-1:0] shift_pout,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  sr_we,
  output logic                  dm_we,
  output logic                  miso_en
`ifdef SPI_TRANSACTION_ABORT_FLAG_EN
  ,
  output logic                  abort_flag
`endif
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_SHIFT = 3'd5,
    WRITE_MEM   = 3'd6,
    DONE        = 3'd7
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic                  busy;

  // States in which a deselect means the transaction was cut short
  assign busy = (state_q != IDLE) && (state_q != DONE);

`ifdef SPI_TRANSACTION_ABORT_FLAG_EN
  logic abort_q, abort_d;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
`ifdef SPI_TRANSACTION_ABORT_FLAG_EN
    abort_d   = abort_q;
`endif
    if (cs) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
`ifdef SPI_TRANSACTION_ABORT_FLAG_EN
      if (busy) abort_d = 1'b1;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = GET_ADDR;
          bit_cnt_d = '0;
`ifdef SPI_TRANSACTION_ABORT_FLAG_EN
          abort_d   = 1'b0;
`endif
        end
        GET_ADDR: begin
          if (sclk_rise) begin
            if (bit_cnt_q == LAST) begin
              state_d   = GOT_ADDR;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
        end
        GOT_ADDR: begin
          addr_d  = shift_pout[ADDR_WIDTH:1];
          rw_d    = shift_pout[0];
          state_d = shift_pout[0] ? READ_LOAD : WRITE_SHIFT;
        end
        READ_LOAD: state_d = READ_SHIFT;
        READ_SHIFT: begin
          if (sclk_fall) begin
            if (bit_cnt_q == LAST) begin
              state_d   = DONE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
        end
        WRITE_SHIFT: begin
          if (sclk_rise) begin
            if (bit_cnt_q == LAST) begin
              state_d   = WRITE_MEM;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
        end
        WRITE_MEM: state_d = DONE;
        DONE:      state_d = DONE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
`ifdef SPI_TRANSACTION_ABORT_FLAG_EN
      abort_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
`ifdef SPI_TRANSACTION_ABORT_FLAG_EN
      abort_q   <= abort_d;
`endif
    end
  end

  // Load/write strobes are killed combinationally by a deselect
  assign sr_we    = (state_q == READ_LOAD) && rw_q && !cs;
  assign dm_we    = (state_q == WRITE_MEM) && !rw_q && !cs;
  assign miso_en  = (state_q == READ_SHIFT);
  assign addr_out = addr_q;
`ifdef SPI_TRANSACTION_ABORT_FLAG_EN
  assign abort_flag = abort_q;
`endif

endmodule

// File: doc/spi_transaction_fsm.md
Name: spi_transaction_fsm

Overview:
Controller that sequences one SPI memory transaction: an address/RW byte, then a data byte either read or written. It watches conditioned chip-select and SCLK edge pulses from the input conditioners, counts bits, latches the address, and drives the control strobes for the shift register (parallel load), the data memory (write enable) and the MISO output buffer. It sits between the conditioners and the shift register / data memory in the SPI memory top level.

Parameters:
ADDR_WIDTH, 7, address bits taken from the first byte.
DATA_WIDTH, 8, bits per byte; the bit counter width is clog2(DATA_WIDTH)+1.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cs  input  1  conditioned chip select, active low (1 = deselected)
sclk_rise  input  1  one-clk pulse, conditioned SCLK rising edge
sclk_fall  input  1  one-clk pulse, conditioned SCLK falling edge
shift_pout  input  DATA_WIDTH  shift register parallel output
addr_out  output  ADDR_WIDTH  latched memory address
sr_we  output  1  shift register parallel-load strobe
dm_we  output  1  data memory write strobe
miso_en  output  1  MISO tri-state buffer enable

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, bit_cnt=0, addr_out=0, rw=0, all strobes 0. Reset wins over every other event, including mid-transaction.
- States: IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_MEM, DONE.
- cs=1 sampled in any state: next state IDLE, bit_cnt cleared. sr_we and dm_we are combinationally forced to 0 in that cycle.
- IDLE: outputs 0. cs=0 -> GET_ADDR with bit_cnt=0. SCLK pulses arriving in IDLE are ignored.
- GET_ADDR: each sclk_rise increments bit_cnt. When a pulse arrives with bit_cnt=DATA_WIDTH-1, the next state is GOT_ADDR with bit_cnt=0. sclk_fall is ignored.
- GOT_ADDR (1 clk): shift_pout now holds the full byte. Registers addr_out<=shift_pout[7:1] and rw<=shift_pout[0]. rw=1 -> READ_LOAD; rw=0 -> WRITE_SHIFT.
- READ_LOAD (1 clk): sr_we=1; the memory read data for addr_out loads into the shift register at the end of this cycle. Next state READ_SHIFT.
- READ_SHIFT: miso_en=1. Each sclk_fall increments bit_cnt. The 8th fall moves to DONE, and miso_en drops on the following clk. sclk_rise is ignored.
- WRITE_SHIFT: each sclk_rise increments bit_cnt. The 8th rise moves to WRITE_MEM.
- WRITE_MEM (1 clk): dm_we=1 with shift_pout = write data and addr_out = address. Next state DONE.
- DONE: all strobes 0. Stays until cs=1, then IDLE. Further SCLK pulses are ignored.
- Strobes are Moore decodes of state, gated only by cs as above. sr_we and dm_we are each exactly 1 clk wide per transaction.
- addr_out holds its value after the transaction until the next GOT_ADDR.
- Latency:
  - address byte complete: 1 clk after the 8th sclk_rise -> GOT_ADDR.
  - read: sr_we 2 clk after the 8th rise.
  - write: dm_we 1 clk after the 8th data rise.

Optional Feature:
SPI_TRANSACTION_ABORT_FLAG_EN: adds output abort_flag (1 bit, reset 0).
- Set, sticky, when cs=1 is sampled in GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT or WRITE_MEM.
- Cleared when IDLE sees cs=0 (start of the next transaction), or on reset.
- Without the macro: the port does not exist, and an abort simply returns to IDLE silently.

Test Plan:
- Write: cs=0, byte 0x2A (addr 0x15, rw=0) on 8 rises, then 0x5A on 8 rises -> one dm_we pulse with addr_out=0x15 and shift_pout=0x5A; no sr_we; state DONE until cs=1, then IDLE.
- Read: cs=0, byte 0x2B on 8 rises -> addr_out=0x15 one clk after GOT_ADDR, sr_we single pulse 2 clk after the 8th rise, miso_en=1 for exactly the 8 falls and 0 one clk after the 8th; no dm_we.
- Abort: cs=0, 4 rises, then cs=1 -> IDLE next clk, no strobes, bit_cnt=0. A following full write to 0x03 succeeds normally. With SPI_TRANSACTION_ABORT_FLAG_EN, abort_flag=1 after the abort and 0 once the new transaction starts.
- Edge filtering:
  - sclk_fall pulses during GET_ADDR and WRITE_SHIFT do not advance bit_cnt.
  - sclk_rise pulses during READ_SHIFT do not advance bit_cnt.
  - extra pulses in DONE: no strobes.
- Reset mid-transaction: rst_n=0 for 1 clk during READ_SHIFT after 3 falls -> IDLE, miso_en=0, addr_out=0, bit_cnt=0 on the next clk. cs held 0 with rst_n=1 re-enters GET_ADDR.
- cs=1 in the same clk as WRITE_MEM -> dm_we stays 0 that cycle; next state IDLE.
